leds_line_driver: RTL

- Serialises one frame of 24-bit GRB pixel words onto the single-wire WS2812-style `LEDS_LINE` strip output, then ends the frame with the latch gap.
- Sits directly downstream of the game/frame logic in the LEDs racer top level:
  - it requests each pixel by index;
  - it samples the colour word that logic returns combinationally;
  - it reports frame completion on `TP_UPDATE_FRAME`.

---
 rtl/leds_line_driver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/leds_line_driver.sv
// -----------------------------------------------------------------------------
// leds_line_driver
//
// Serialises one frame of 24-bit GRB pixel words onto a single-wire
// WS2812-style LED strip, then holds the line low for the latch gap.
// Pixels are requested one at a time by index. The upstream frame logic
// answers combinationally on LED_GRB, and the word is captured in a one-cycle
// LOAD state before its 24 bits are sent MSB first (G, R, B).
//
// Ports:
//   CLK              in   system clock, rising edge
//   FORCE_RESET_N    in   synchronous active-low reset
//   START            in   frame request, sampled only while idle
//   LED_INDEX        out  index of the pixel being requested (registered)
//   LED_GRB          in   colour of LED_INDEX: [23:16]=G [15:8]=R [7:0]=B
//   LEDS_LINE        out  serial strip data (registered)
//   BUSY             out  high while a frame or latch gap is in progress
//   TP_UPDATE_FRAME  out  one-cycle pulse once a frame has been latched
//
// Build option:
//   LEDS_LINE_DRIVER_AUTO_REFRESH_EN - when defined, START is ignored and a
//   new frame begins one cycle after the previous one ends, so the strip is
//   refreshed continuously.
// -----------------------------------------------------------------------------
module leds_line_driver #(
    parameter int unsigned NUM_LEDS     = 16,
    parameter int unsigned BIT_CYCLES   = 63,
    parameter int unsigned T0H_CYCLES   = 20,
    parameter int unsigned T1H_CYCLES   = 40,
    parameter int unsigned RESET_CYCLES = 2500,
    localparam int unsigned IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             CLK,
    input  logic             FORCE_RESET_N,
    input  logic             START,
    output logic [IDX_W-1:0] LED_INDEX,
    input  logic [23:0]      LED_GRB,
    output logic             LEDS_LINE,
    output logic             BUSY,
    output logic             TP_UPDATE_FRAME
);

    // Counter sized for the longest interval it ever has to time.
    localparam int unsigned CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: the counter runs 0..N-1 within each phase.
    localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0L_LAST = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1L_LAST = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

`ifdef LEDS_LINE_DRIVER_AUTO_REFRESH_EN
    localparam bit AUTO_REFRESH = 1'b1;
    // START has no function in this build.
    logic unused_start;
    assign unused_start = START;
    wire  frame_req = 1'b1;
`else
    localparam bit AUTO_REFRESH = 1'b0;
    wire  frame_req = START;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             line_q, line_d;
    logic             tp_q, tp_d;
    logic [CNT_W-1:0] high_last;
    logic [CNT_W-1:0] low_last;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tp_d      = 1'b0;

        // The MSB of the shift register is the bit currently on the wire;
        // it stays stable across both the HIGH and LOW phases of that bit.
        high_last = shift_q[23] ? T1H_LAST : T0H_LAST;
        low_last  = shift_q[23] ? T1L_LAST : T0L_LAST;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (AUTO_REFRESH || frame_req) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                // Only the colour present during this cycle is ever used.
                shift_d   = LED_GRB;
                bit_cnt_d = 5'd23;
                cnt_d     = '0;
                state_d   = ST_HIGH;
            end
            ST_HIGH: begin
                if (cnt_q == high_last) begin
                    cnt_d   = '0;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_q == low_last) begin
                    cnt_d = '0;
                    if (bit_cnt_q != 5'd0) begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        state_d   = ST_HIGH;
                    end else if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    tp_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // The line register follows the next state so that LEDS_LINE is
        // high exactly during the cycles the FSM spends in HIGH.
        line_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge CLK) begin
        if (!FORCE_RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            line_q    <= 1'b0;
            tp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
            tp_q      <= tp_d;
        end
    end

    assign LED_INDEX       = idx_q;
    assign LEDS_LINE       = line_q;
    assign BUSY            = (state_q != ST_IDLE);
    assign TP_UPDATE_FRAME = tp_q;

endmodule
